// File: rtl/clk_div_gen.sv
// Runtime-programmable clock divider. It produces a registered divided clock, a period tick,
// and a handshaked divisor update. Define CLKDIV_SYNC_EN to add the sync_in phase-restart input.
module clk_div_gen #(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 4
) (
    input  logic             clk100MHz,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             div_ack,
    output logic             div_err,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [CNT_W-1:0] div_cur
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pend_div;
    logic             pend_vld;

    logic             load_ok;
    logic             wrap;
    logic             force_wrap;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] eff_div;
    logic             upd;

    assign load_ok = div_load && (div_in >= CNT_W'(2));
    assign cnt_nxt = cnt + CNT_W'(1);
    assign wrap    = (cnt == div_cur - CNT_W'(1));
    assign half    = div_cur >> 1;
    // A load arriving on the wrap edge itself beats anything already pending.
    assign eff_div = load_ok ? div_in : pend_div;
    assign upd     = load_ok || pend_vld;

`ifdef CLKDIV_SYNC_EN
    assign force_wrap = sync_in;
`else
    assign force_wrap = 1'b0;
`endif

    always_ff @(posedge clk100MHz) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            div_cur  <= CNT_W'(DIV_DEFAULT);
            pend_vld <= 1'b0;
            pend_div <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            div_ack  <= 1'b0;
            div_err  <= 1'b0;
            running  <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here; later non-blocking writes in this block win.
            tick    <= 1'b0;
            div_ack <= 1'b0;
            div_err <= div_load && !load_ok;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    clk_out <= 1'b0;
                    running <= 1'b0;
                    if (load_ok) begin
                        div_cur <= div_in;
                        div_ack <= 1'b1;
                    end
                    if (en) begin
                        state   <= RUN;
                        clk_out <= 1'b1;
                        tick    <= 1'b1;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (wrap || force_wrap) begin
                        cnt <= '0;
                        if (upd) begin
                            div_cur  <= eff_div;
                            pend_vld <= 1'b0;
                            div_ack  <= 1'b1;
                        end
                        // en only matters at the period boundary, so a pulse is never cut short.
                        if (en || force_wrap) begin
                            clk_out <= 1'b1;
                            tick    <= 1'b1;
                            running <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            clk_out <= 1'b0;
                            running <= 1'b0;
                        end
                    end else begin
                        cnt     <= cnt_nxt;
                        clk_out <= (cnt_nxt < half);
                        if (load_ok) begin
                            pend_div <= div_in;
                            pend_vld <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen. Expected output words are queued as stimulus is driven.
// Each word is popped and compared 1 ns after the clock edge that produces it.
module tb_clk_div_gen;

    localparam int CNT_W = 8;

    logic             clk100MHz;
    logic             reset;
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_load;
    logic             sync_in;
    logic             div_ack;
    logic             div_err;
    logic             clk_out;
    logic             tick;
    logic             running;
    logic [CNT_W-1:0] div_cur;

    logic [12:0] obs;
    logic [12:0] exp_q[$];
    int          n_total = 0;
    int          n_bad   = 0;

    assign obs = {clk_out, tick, div_ack, div_err, running, div_cur};

    clk_div_gen #(.CNT_W(CNT_W), .DIV_DEFAULT(4)) dut (
        .clk100MHz (clk100MHz),
        .reset     (reset),
        .en        (en),
        .div_in    (div_in),
        .div_load  (div_load),
`ifdef CLKDIV_SYNC_EN
        .sync_in   (sync_in),
`endif
        .div_ack   (div_ack),
        .div_err   (div_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running),
        .div_cur   (div_cur)
    );

    initial clk100MHz = 1'b0;
    always #5 clk100MHz = ~clk100MHz;

    initial begin
        #100us;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    // Packs expected {clk_out, tick, div_ack, div_err, running, div_cur}.
    function automatic logic [12:0] ex(input bit c, input bit t, input bit a, input bit e,
                                       input bit r, input logic [7:0] d);
        return {c, t, a, e, r, d};
    endfunction

    task automatic cyc();
        @(posedge clk100MHz);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0; sync_in = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] w;
        reset = 1'b1; en = 1'b1; div_load = 1'b1; div_in = 8'd9; sync_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin reset = 1'b0; en = 1'b0; div_load = 1'b0; end
            exp_q.push_back(ex(0, 0, 0, 0, 0, 4));
            cyc();
            w = exp_q.pop_front();
            n_total++;
            if (obs !== w) begin
                n_bad++;
                $display("FAIL reset k=%0d got=%b want=%b", k, obs, w);
            end
        end
    endtask

    task automatic test_default();
        logic [12:0] w;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            exp_q.push_back(ex(k % 4 < 2, k % 4 == 0, 0, 0, 1, 4));
            cyc();
            w = exp_q.pop_front();
            n_total++;
            if (obs !== w) begin
                n_bad++;
                $display("FAIL default k=%0d got=%b want=%b", k, obs, w);
            end
        end
    endtask

    task automatic test_div_change();
        logic [12:0] w;
        int p;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 15; k++) begin
            div_load = (k == 2);
            div_in   = 8'd5;
            p = (k - 4) % 5;
            if (k < 4) exp_q.push_back(ex(k < 2, k == 0, 0, 0, 1, 4));
            else       exp_q.push_back(ex(p < 2, p == 0, k == 4, 0, 1, 5));
            cyc();
            w = exp_q.pop_front();
            n_total++;
            if (obs !== w) begin
                n_bad++;
                $display("FAIL div_change k=%0d got=%b want=%b", k, obs, w);
            end
        end
        div_load = 1'b0;
    endtask

    task automatic test_div_err();
        logic [12:0] w;
        bit bad_ld;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bad_ld   = (k == 1 || k == 2 || k == 4);
            div_load = bad_ld;
            div_in   = (k == 2) ? 8'd0 : 8'd1;
            exp_q.push_back(ex(k % 4 < 2, k % 4 == 0, 0, bad_ld, 1, 4));
            cyc();
            w = exp_q.pop_front();
            n_total++;
            if (obs !== w) begin
                n_bad++;
                $display("FAIL div_err k=%0d got=%b want=%b", k, obs, w);
            end
        end
        div_load = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [12:0] w;
        int p;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            div_load = (k == 1 || k == 2 || k == 6 || k == 10);
            div_in   = (k == 1) ? 8'd7 : (k == 2) ? 8'd6 : (k == 6) ? 8'd8 : 8'd3;
            if (k < 4) begin
                exp_q.push_back(ex(k < 2, k == 0, 0, 0, 1, 4));
            end else if (k < 10) begin
                p = (k - 4) % 6;
                exp_q.push_back(ex(p < 3, p == 0, k == 4, 0, 1, 6));
            end else begin
                p = (k - 10) % 3;
                exp_q.push_back(ex(p < 1, p == 0, k == 10, 0, 1, 3));
            end
            cyc();
            w = exp_q.pop_front();
            n_total++;
            if (obs !== w) begin
                n_bad++;
                $display("FAIL back_to_back k=%0d got=%b want=%b", k, obs, w);
            end
        end
        div_load = 1'b0;
    endtask

    task automatic test_en_drop();
        logic [12:0] w;
        int p;
        do_reset();
        for (int k = 0; k < 11; k++) begin
            en       = !(k >= 2 && k <= 6);
            div_load = (k == 2);
            div_in   = 8'd3;
            if (k < 2) begin
                exp_q.push_back(ex(1, k == 0, 0, 0, 1, 4));
            end else if (k < 4) begin
                exp_q.push_back(ex(0, 0, 0, 0, 1, 4));
            end else if (k < 7) begin
                exp_q.push_back(ex(0, 0, k == 4, 0, 0, 3));
            end else begin
                p = (k - 7) % 3;
                exp_q.push_back(ex(p == 0, p == 0, 0, 0, 1, 3));
            end
            cyc();
            w = exp_q.pop_front();
            n_total++;
            if (obs !== w) begin
                n_bad++;
                $display("FAIL en_drop k=%0d got=%b want=%b", k, obs, w);
            end
        end
        div_load = 1'b0;
    endtask

    task automatic test_idle_load();
        logic [12:0] w;
        int p;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            en       = (k != 0);
            div_load = (k == 0);
            div_in   = 8'd2;
            p = (k - 1) % 2;
            if (k == 0) exp_q.push_back(ex(0, 0, 1, 0, 0, 2));
            else        exp_q.push_back(ex(p == 0, p == 0, 0, 0, 1, 2));
            cyc();
            w = exp_q.pop_front();
            n_total++;
            if (obs !== w) begin
                n_bad++;
                $display("FAIL idle_load k=%0d got=%b want=%b", k, obs, w);
            end
        end
        div_load = 1'b0;
    endtask

    task automatic test_reset_pending();
        logic [12:0] w;
        int p;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 13; k++) begin
            reset    = (k == 2);
            div_load = (k == 1);
            div_in   = 8'd6;
            p = (k - 3) % 4;
            if (k < 2)       exp_q.push_back(ex(1, k == 0, 0, 0, 1, 4));
            else if (k == 2) exp_q.push_back(ex(0, 0, 0, 0, 0, 4));
            else             exp_q.push_back(ex(p < 2, p == 0, 0, 0, 1, 4));
            cyc();
            w = exp_q.pop_front();
            n_total++;
            if (obs !== w) begin
                n_bad++;
                $display("FAIL reset_pending k=%0d got=%b want=%b", k, obs, w);
            end
        end
        reset    = 1'b0;
        div_load = 1'b0;
    endtask

`ifdef CLKDIV_SYNC_EN
    task automatic test_sync();
        logic [12:0] w;
        int p;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            sync_in  = (k == 3 || k == 5);
            en       = (k != 5);
            div_load = (k == 4);
            div_in   = 8'd2;
            p = (k - 5) % 2;
            if (k < 3)       exp_q.push_back(ex(k < 2, k == 0, 0, 0, 1, 4));
            else if (k == 3) exp_q.push_back(ex(1, 1, 0, 0, 1, 4));
            else if (k == 4) exp_q.push_back(ex(1, 0, 0, 0, 1, 4));
            else             exp_q.push_back(ex(p == 0, p == 0, k == 5, 0, 1, 2));
            cyc();
            w = exp_q.pop_front();
            n_total++;
            if (obs !== w) begin
                n_bad++;
                $display("FAIL sync k=%0d got=%b want=%b", k, obs, w);
            end
        end
        sync_in  = 1'b0;
        div_load = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0; sync_in = 1'b0;
        #2;
        test_reset();
        test_default();
        test_div_change();
        test_div_err();
        test_back_to_back();
        test_en_drop();
        test_idle_load();
        test_reset_pending();
`ifdef CLKDIV_SYNC_EN
        test_sync();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
